m_unit_issuer: RTL
==================

Name: m_unit_issuer

Overview:
- Core-side initiator for the M-extension coprocessor interface (valid/insn/rs1/rs2 out; wr/rd/busy/ready in).
- Accepts one decoded R-type instruction plus operand values from the core's execute stage.
- Checks that the instruction is RV32M, drives the coprocessor handshake and holds it until completion.
- Returns the result as a single-cycle register-file writeback, or flags an illegal instruction.

Parameters:
- TIMEOUT_CYCLES, 64: cycles `pcpi_valid` may stay high without `pcpi_ready` before an illegal-instruction trap (used only with the optional feature).
- CNT_W, 8: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- issue_valid  input  1  core presents an instruction
- issue_ready  output  1  issuer can accept (high only in IDLE)
- issue_instr  input  32  instruction word
- issue_rs1  input  32  rs1 operand value
- issue_rs2  input  32  rs2 operand value
- flush  input  1  pipeline flush; abort any in-flight operation
- pcpi_valid  output  1  request to M unit
- pcpi_insn  output  32  registered instruction
- pcpi_rs1  output  32  registered rs1 value
- pcpi_rs2  output  32  registered rs2 value
- pcpi_wr  input  1  M unit result is to be written
- pcpi_rd  input  32  M unit result
- pcpi_busy  input  1  M unit is working (informational only)
- pcpi_ready  input  1  M unit completion strobe
- wb_valid  output  1  one-cycle register-file write strobe
- wb_addr  output  5  destination register, instr[11:7]
- wb_data  output  32  write data
- done  output  1  one-cycle completion pulse (with or without write)
- illegal  output  1  one-cycle illegal-instruction pulse

Behaviour:
- Reset (async, active-high):
  - state = IDLE.
  - All outputs 0 except `issue_ready` = 1.
  - `pcpi_insn`/`pcpi_rs1`/`pcpi_rs2` = 0; timeout counter = 0.
- M-instruction decode: instr[6:0] == 7'b0110011 and instr[31:25] == 7'b0000001. Any funct3 is legal.
- Accept: `issue_valid && issue_ready` at a clock edge.
  - M instruction: register instr, rs1 and rs2; state -> REQ.
  - Otherwise: `illegal` = 1 next cycle; state stays IDLE; nothing issued.
- States:
  - IDLE: `issue_ready` = 1, `pcpi_valid` = 0.
  - REQ: `pcpi_valid` = 1; `pcpi_insn`/`pcpi_rs1`/`pcpi_rs2` held stable. Exits when `pcpi_ready` is sampled high.
  - RESP: single cycle. Drive `done` = 1. If the captured `pcpi_wr` = 1 and rd != 0, also drive `wb_valid` = 1, `wb_data` = captured `pcpi_rd`, `wb_addr` = insn[11:7]. Then -> IDLE.
- Latency:
  - Accept at edge N -> `pcpi_valid` high from N+1.
  - `pcpi_ready` sampled at edge M -> `pcpi_valid` low and `done`/`wb_valid` high in cycle M+1.
  - `issue_ready` returns at M+2.
  - `pcpi_ready` sampled in the same edge as acceptance is ignored (`pcpi_valid` was low). Minimum op = 3 cycles accept-to-accept.
- `pcpi_wr` and `pcpi_rd` are sampled only on the edge where `pcpi_ready` = 1 in REQ. Values at other times are ignored.
- Writeback suppression:
  - rd = x0 -> `wb_valid` = 0, `done` = 1.
  - `pcpi_wr` = 0 with `pcpi_ready` = 1 -> `wb_valid` = 0, `done` = 1.
- `wb_data`/`wb_addr` hold their last values outside `wb_valid` (no X).
- `flush`:
  - Any state -> IDLE at the next edge; `pcpi_valid` drops; no `done`/`wb_valid`/`illegal`.
  - `flush` has priority over a simultaneous `pcpi_ready` or accept.
- `pcpi_busy` does not affect state transitions.
- Reset mid-operation: immediate return to reset values; the in-flight result is discarded.

Optional Feature:
- Macro: `M_ISSUER_TIMEOUT_EN`.
- Defined:
  - Counter clears on entry to REQ and increments each REQ cycle without `pcpi_ready`.
  - On reaching TIMEOUT_CYCLES: `pcpi_valid` drops, `illegal` pulses 1 cycle, state -> IDLE, no writeback.
  - `pcpi_ready` on the same edge as the limit wins (normal completion).
- Undefined: no counter; REQ waits indefinitely for `pcpi_ready`.

Test Plan:
- MUL accept: insn 0x02208033 (mul x0? no — use 0x022081B3, mul x3,x1,x2), rs1 = 6, rs2 = 7; M unit returns `pcpi_ready` = `pcpi_wr` = 1, `pcpi_rd` = 42 three cycles later -> one `wb_valid` cycle with addr 3, data 42, `done` = 1; `issue_ready` high again the following cycle.
- Non-M instruction: ADD 0x002081B3 -> `illegal` pulse 1 cycle; `pcpi_valid` stays 0; no `wb_valid`.
- rd = x0: 0x02208033 with `pcpi_wr` = 1 -> `done` = 1, `wb_valid` = 0.
- `pcpi_ready` with `pcpi_wr` = 0 -> `done` = 1, `wb_valid` = 0.
- Flush: `flush` asserted in REQ on the same edge as `pcpi_ready` -> IDLE; no `done`/`wb_valid`.
- With `M_ISSUER_TIMEOUT_EN`, TIMEOUT_CYCLES = 4, M unit never ready -> `pcpi_valid` high exactly 4 cycles, then `illegal` pulse and IDLE.
- Reset asserted mid-REQ -> `pcpi_valid` = 0 immediately; `issue_ready` = 1.

Source files
------------

// File: rtl/m_unit_issuer.sv
// Core-side issuer for the RV32M coprocessor handshake: decode, request, single-cycle writeback.
// Optional REQ watchdog enabled by defining M_ISSUER_TIMEOUT_EN.
module m_unit_issuer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [31:0] issue_instr,
  input  logic [31:0] issue_rs1,
  input  logic [31:0] issue_rs2,
  input  logic        flush,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  output logic [31:0] pcpi_rs1,
  output logic [31:0] pcpi_rs2,
  input  logic        pcpi_wr,
  input  logic [31:0] pcpi_rd,
  input  logic        pcpi_busy,
  input  logic        pcpi_ready,
  output logic        wb_valid,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t state, state_nxt;
  logic   is_m, accept, take_rsp, tmo, wr_q;

  assign is_m     = (issue_instr[6:0] == 7'b0110011) && (issue_instr[31:25] == 7'b0000001);
  assign accept   = issue_valid && (state == IDLE);
  assign take_rsp = (state == REQ) && pcpi_ready && !flush;

`ifdef M_ISSUER_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;

  // Ready on the limit edge still completes normally.
  assign tmo = (state == REQ) && !pcpi_ready && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               cnt <= '0;
    else if (state != REQ)   cnt <= '0;
    else if (!pcpi_ready)    cnt <= cnt + 1'b1;
  end

  logic unused_busy;
  assign unused_busy = pcpi_busy;
`else
  assign tmo = 1'b0;

  logic unused_cfg;
  assign unused_cfg = pcpi_busy ^ (CNT_W'(TIMEOUT_CYCLES) == '0);
`endif

  always_comb begin
    state_nxt = state;
    if (flush) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (accept && is_m) state_nxt = REQ;
        REQ:     if (pcpi_ready)     state_nxt = RESP;
                 else if (tmo)       state_nxt = IDLE;
        RESP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcpi_insn <= '0;
      pcpi_rs1  <= '0;
      pcpi_rs2  <= '0;
      wr_q      <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
      illegal   <= 1'b0;
    end else begin
      if (accept && is_m && !flush) begin
        pcpi_insn <= issue_instr;
        pcpi_rs1  <= issue_rs1;
        pcpi_rs2  <= issue_rs2;
      end
      // Result fields only move when a real write is coming, so they hold between writes.
      if (take_rsp) begin
        wr_q <= pcpi_wr && (pcpi_insn[11:7] != 5'd0);
        if (pcpi_wr && (pcpi_insn[11:7] != 5'd0)) begin
          wb_addr <= pcpi_insn[11:7];
          wb_data <= pcpi_rd;
        end
      end
      illegal <= !flush && ((accept && !is_m) || tmo);
    end
  end

  assign issue_ready = (state == IDLE);
  assign pcpi_valid  = (state == REQ);
  assign done        = (state == RESP);
  assign wb_valid    = (state == RESP) && wr_q;

endmodule
